fwd_hazard_ctrl: RTL and testbench

Pipeline controller that drives the two 2-bit select inputs of the EX-stage 4:1 operand muxes (ALU operand A and B). It keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB control fields (rd, reg-write, mem-read, rs1/rs2). From that copy it detects load-use hazards and controls PC / IF-ID writes and ID/EX bubbles. It sits beside the hazard-detection path, and its select outputs wire directly to the operand mux selects.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 20 ++
 rtl/fwd_hazard_ctrl_fwd_sel.sv | 23 ++
 rtl/fwd_hazard_ctrl.sv | 97 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared constants and shadow-stage type for the forwarding/hazard controller
package fwd_hazard_ctrl_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              regwrite;
      logic              memread;
   } stage_t;

   localparam stage_t STAGE_NOP = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// rtl/fwd_hazard_ctrl_fwd_sel.sv - one operand mux select from the MEM/WB shadow destinations
module fwd_sel_unit
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] ex_rs_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              mem_regwrite_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_regwrite_i,
   output logic [1:0]        sel_o
);

   // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
   always_comb begin
      sel_o = FWD_REG;
      if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
         sel_o = FWD_MEM;
      end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - shadow ID/EX, EX/MEM, MEM/WB fields driving forwarding selects and load-use stalls
module fwd_hazard_ctrl #(
   parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_ext_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              idex_bubble_o,
   output logic [CNT_W-1:0]  lu_stall_cnt_o
);
   import fwd_hazard_ctrl_pkg::*;

   stage_t           ex_q, ex_d, mem_q, wb_q;
   logic [CNT_W-1:0] cnt_q;
   logic             lu;
   logic             lu_apply;

   assign lu = id_valid_i && ex_q.memread && (ex_q.rd != '0) &&
               ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

   assign lu_apply = lu && !stall_ext_i && !flush_i;

   // Priority: reset, external stall, flush, then load-use.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_bubble_o = 1'b0;
      ex_d          = STAGE_NOP;
      if (id_valid_i) begin
         ex_d = '{rd: id_rd_i, rs1: id_rs1_i, rs2: id_rs2_i,
                  regwrite: id_regwrite_i, memread: id_memread_i};
      end
      if (rst_i) begin
         ex_d = STAGE_NOP;
      end else if (stall_ext_i) begin
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
      end else if (flush_i) begin
         idex_bubble_o = 1'b1;
         ex_d          = STAGE_NOP;
      end else if (lu) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
         ex_d          = STAGE_NOP;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_q  <= STAGE_NOP;
         mem_q <= STAGE_NOP;
         wb_q  <= STAGE_NOP;
         cnt_q <= '0;
      end else if (!stall_ext_i) begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
         if (lu_apply && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign lu_stall_cnt_o = cnt_q;

   fwd_sel_unit u_sel_a (
      .ex_rs_i        (ex_q.rs1),
      .mem_rd_i       (mem_q.rd),
      .mem_regwrite_i (mem_q.regwrite),
      .wb_rd_i        (wb_q.rd),
      .wb_regwrite_i  (wb_q.regwrite),
      .sel_o          (fwd_a_o)
   );

   fwd_sel_unit u_sel_b (
      .ex_rs_i        (ex_q.rs2),
      .mem_rd_i       (mem_q.rd),
      .mem_regwrite_i (mem_q.regwrite),
      .wb_rd_i        (wb_q.rd),
      .wb_regwrite_i  (wb_q.regwrite),
      .sel_o          (fwd_b_o)
   );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

   localparam int AW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          stall_ext_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          id_valid_i = 1'b0;
   logic [AW-1:0] id_rs1_i = '0;
   logic [AW-1:0] id_rs2_i = '0;
   logic [AW-1:0] id_rd_i = '0;
   logic          id_regwrite_i = 1'b0;
   logic          id_memread_i = 1'b0;

   logic [1:0]  fwd_a_o, fwd_b_o;
   logic        pc_write_o, ifid_write_o, idex_bubble_o;
   logic [15:0] lu_stall_cnt_o;

   logic [1:0]  fwd_a_s, fwd_b_s;
   logic        pc_write_s, ifid_write_s, idex_bubble_s;
   logic [3:0]  cnt_s;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_ext_i(stall_ext_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .pc_write_o(pc_write_o),
      .ifid_write_o(ifid_write_o), .idex_bubble_o(idex_bubble_o), .lu_stall_cnt_o(lu_stall_cnt_o)
   );

   fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(4)) dut_sat (
      .clk_i(clk_i), .rst_i(rst_i), .stall_ext_i(stall_ext_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
      .fwd_a_o(fwd_a_s), .fwd_b_o(fwd_b_s), .pc_write_o(pc_write_s),
      .ifid_write_o(ifid_write_s), .idex_bubble_o(idex_bubble_s), .lu_stall_cnt_o(cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one ID-stage slot just after a rising edge; outputs are settled on return.
   task automatic issue(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic rw, input logic mr,
                        input logic st, input logic fl);
      @(posedge clk_i);
      #1;
      id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
      id_regwrite_i = rw; id_memread_i = mr; stall_ext_i = st; flush_i = fl;
      #2;
   endtask

   task automatic nop();
      issue(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ctl(input string tag, input logic pc, input logic ifid, input logic bub);
      chk({tag, "_pc"}, {31'd0, pc_write_o}, {31'd0, pc});
      chk({tag, "_ifid"}, {31'd0, ifid_write_o}, {31'd0, ifid});
      chk({tag, "_bubble"}, {31'd0, idex_bubble_o}, {31'd0, bub});
   endtask

   initial begin
      #3;
      chk("rst_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      chk("rst_fwd_b", {30'd0, fwd_b_o}, 32'd0);
      ctl("rst", 1'b1, 1'b1, 1'b0);
      chk("rst_cnt", {16'd0, lu_stall_cnt_o}, 32'd0);
      #10 rst_i = 1'b0;

      // NOP stream
      for (int i = 0; i < 4; i++) nop();
      chk("nop_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      chk("nop_fwd_b", {30'd0, fwd_b_o}, 32'd0);
      ctl("nop", 1'b1, 1'b1, 1'b0);
      chk("nop_cnt", {16'd0, lu_stall_cnt_o}, 32'd0);

      // add x5; sub rs1=x5; then rs2=x5 two slots after the add
      issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mem_fwd_a", {30'd0, fwd_a_o}, 32'd2);
      chk("mem_fwd_b", {30'd0, fwd_b_o}, 32'd0);
      nop();
      chk("wb_fwd_b", {30'd0, fwd_b_o}, 32'd1);
      chk("wb_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      nop(); nop(); nop();

      // MEM and WB both write x7: MEM wins
      issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 5'd7, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      nop();
      chk("prio_fwd_a", {30'd0, fwd_a_o}, 32'd2);
      chk("prio_fwd_b", {30'd0, fwd_b_o}, 32'd2);
      nop(); nop(); nop();

      // same with x0 as destination: never forwarded
      issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      nop();
      chk("x0_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      chk("x0_fwd_b", {30'd0, fwd_b_o}, 32'd0);
      nop(); nop(); nop();

      // lw x3; add rs2=x3 -> one stall cycle, then WB forward
      issue(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 5'd4, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      ctl("lu", 1'b0, 1'b0, 1'b1);
      chk("lu_cnt_before", {16'd0, lu_stall_cnt_o}, 32'd0);
      issue(1'b1, 5'd4, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      ctl("lu_after", 1'b1, 1'b1, 1'b0);
      chk("lu_cnt", {16'd0, lu_stall_cnt_o}, 32'd1);
      nop();
      chk("lu_fwd_b", {30'd0, fwd_b_o}, 32'd1);
      chk("lu_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      nop(); nop(); nop();

      // load-use under external stall for 3 cycles
      issue(1'b1, 5'd2, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 5'd4, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
         ctl($sformatf("stall%0d", i), 1'b0, 1'b0, 1'b0);
         chk($sformatf("stall%0d_fwd_a", i), {30'd0, fwd_a_o}, 32'd2);
         chk($sformatf("stall%0d_cnt", i), {16'd0, lu_stall_cnt_o}, 32'd1);
      end
      issue(1'b1, 5'd4, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      ctl("stall_drop", 1'b0, 1'b0, 1'b1);
      issue(1'b1, 5'd4, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stall_drop_cnt", {16'd0, lu_stall_cnt_o}, 32'd2);
      nop(); nop(); nop();

      // load-use with flush: bubble without stall, not counted
      issue(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
      ctl("flush", 1'b1, 1'b1, 1'b1);
      nop();
      chk("flush_cnt", {16'd0, lu_stall_cnt_o}, 32'd2);
      chk("flush_sat_cnt", {28'd0, cnt_s}, 32'd2);
      nop(); nop();

      // lw x3,0(x3) back to back: load-use every other cycle, 20 in total
      for (int i = 0; i < 40; i++) issue(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      nop();
      chk("many_cnt", {16'd0, lu_stall_cnt_o}, 32'd22);
      chk("sat_cnt", {28'd0, cnt_s}, 32'd15);
      nop();
      chk("sat_hold", {28'd0, cnt_s}, 32'd15);

      // reset arriving mid-stall
      issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      rst_i = 1'b1;
      #1;
      ctl("rst_mid", 1'b1, 1'b1, 1'b0);
      chk("rst_mid_cnt", {16'd0, lu_stall_cnt_o}, 32'd0);
      chk("rst_mid_fwd_a", {30'd0, fwd_a_o}, 32'd0);
      #10 rst_i = 1'b0;
      stall_ext_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
